// File: rtl/example_call_driver.sv
// Batch call driver: issues cmd_count component calls under a credit limit and
// buffers the returns in a DEPTH-entry result FIFO, summing them per batch.
module example_call_driver #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [15:0] cmd_count,
  output logic        call_start,
  input  logic        call_busy,
  input  logic        ret_done,
  output logic        ret_stall,
  input  logic [31:0] ret_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [47:0] batch_sum,
  output logic        batch_done,
  output logic        err_unexp
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DepthCred = (AW+2)'(DEPTH);
  localparam logic [AW:0]   DepthCnt  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OneCnt    = (AW+1)'(1);
  localparam logic [AW-1:0] OnePtr    = AW'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e          state_q, state_d;
  logic [15:0]     remaining_q, remaining_d;
  logic [AW:0]     outstanding_q, outstanding_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [31:0]     mem_q [DEPTH];
  logic [47:0]     batch_sum_q, batch_sum_d;
  logic            batch_done_q, batch_done_d;
  logic            err_unexp_q;
  logic [AW+1:0]   credits_used;
  logic            call_acc, ret_acc, push, pop;

  // Outstanding calls plus buffered results may never exceed the FIFO depth.
  assign credits_used = {1'b0, outstanding_q} + {1'b0, count_q};

  assign cmd_ready  = (state_q == StIdle);
  assign call_start = (state_q == StIssue) && (remaining_q != '0) && (credits_used < DepthCred);
  assign call_acc   = call_start & ~call_busy;
  assign ret_stall  = (count_q == DepthCnt);
  assign ret_acc    = ret_done & ~ret_stall;
  assign push       = ret_acc & (outstanding_q != '0);
  assign res_valid  = (count_q != '0);
  assign pop        = res_valid & res_ready;
  assign res_data   = mem_q[rd_ptr_q];
  assign batch_sum  = batch_sum_q;
  assign batch_done = batch_done_q;
  assign err_unexp  = err_unexp_q;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    batch_sum_d   = batch_sum_q;
    batch_done_d  = 1'b0;
    outstanding_d = outstanding_q;
    count_d       = count_q;

    case ({call_acc, push})
      2'b10:   outstanding_d = outstanding_q + OneCnt;
      2'b01:   outstanding_d = outstanding_q - OneCnt;
      default: outstanding_d = outstanding_q;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + OneCnt;
      2'b01:   count_d = count_q - OneCnt;
      default: count_d = count_q;
    endcase

    if (push) batch_sum_d = batch_sum_q + {16'd0, ret_data};

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          batch_sum_d = '0;
          if (cmd_count != '0) begin
            remaining_d = cmd_count;
            state_d     = StIssue;
          end else begin
            batch_done_d = 1'b1;
          end
        end
      end
      StIssue: begin
        if (call_acc) begin
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = StDrain;
        end
      end
      StDrain: begin
        if (outstanding_q == '0) begin
          state_d      = StIdle;
          batch_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      remaining_q   <= '0;
      outstanding_q <= '0;
      count_q       <= '0;
      batch_sum_q   <= '0;
      batch_done_q  <= 1'b0;
      err_unexp_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      batch_sum_q   <= batch_sum_d;
      batch_done_q  <= batch_done_d;
      if (ret_acc && (outstanding_q == '0)) err_unexp_q <= 1'b1;
    end
  end

  // Storage is reset so the head reads zero out of reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= ret_data;
        wr_ptr_q        <= wr_ptr_q + OnePtr;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + OnePtr;
    end
  end

endmodule

// File: tb/tb_example_call_driver.sv
// Bench for example_call_driver: directed scenarios then randomized batches, all
// checked against a transaction-level model (counts plus a result queue).
module tb_example_call_driver;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_count = '0;
  logic        call_start;
  logic        call_busy = 1'b0;
  logic        ret_done = 1'b0;
  logic        ret_stall;
  logic [31:0] ret_data = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [47:0] batch_sum;
  logic        batch_done;
  logic        err_unexp;

  example_call_driver #(.DEPTH(DEPTH)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_count (cmd_count),
    .call_start(call_start),
    .call_busy (call_busy),
    .ret_done  (ret_done),
    .ret_stall (ret_stall),
    .ret_data  (ret_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .batch_sum (batch_sum),
    .batch_done(batch_done),
    .err_unexp (err_unexp)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: batch in progress, calls left, calls awaiting return, result queue.
  bit          m_inbatch;
  int          m_rem;
  int          m_out;
  logic [31:0] m_q[$];
  logic [47:0] m_sum;
  bit          m_err;
  bit          m_done;

  // Component stand-in and observation bookkeeping.
  logic [31:0] comp_q[$];
  logic [31:0] dir_q[$];
  logic [31:0] obs_pops[$];
  logic [47:0] gen_sum;
  bit          comp_en = 1'b1;
  bit          rand_mode = 1'b0;
  int          ret_pct = 100;
  int          obs_calls = 0;
  int          obs_done = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inbatch = 0; m_rem = 0; m_out = 0; m_q.delete();
    m_sum = '0; m_err = 0; m_done = 0;
    comp_q.delete(); dir_q.delete();
  endtask

  task automatic tick();
    bit e_cs, e_stall, e_valid, c_acc, r_acc, pop, dn;
    logic [31:0] d;
    if (rand_mode) begin
      call_busy = ($urandom_range(3) == 0);
      res_ready = $urandom_range(1);
    end
    if (comp_en) begin
      ret_done = (comp_q.size() > 0) && ($urandom_range(99) < ret_pct);
      ret_data = ret_done ? comp_q[0] : $urandom;
    end
    e_cs    = m_inbatch && (m_rem > 0) && ((m_out + m_q.size()) < DEPTH);
    e_stall = (m_q.size() == DEPTH);
    e_valid = (m_q.size() > 0);
    check("cmd_ready", cmd_ready, !m_inbatch);
    check("call_start", call_start, e_cs);
    check("ret_stall", ret_stall, e_stall);
    check("res_valid", res_valid, e_valid);
    if (e_valid) check("res_data", res_data, m_q[0]);
    check("batch_sum", batch_sum, m_sum);
    check("batch_done", batch_done, m_done);
    check("err_unexp", err_unexp, m_err);
    if (call_start && !call_busy) obs_calls++;
    if (batch_done) obs_done++;
    if (res_valid && res_ready) obs_pops.push_back(res_data);

    c_acc = e_cs && !call_busy;
    r_acc = ret_done && !e_stall;
    pop   = e_valid && res_ready;
    dn    = 0;
    if (!m_inbatch && cmd_valid) begin
      m_sum = '0;
      if (cmd_count != 0) begin m_inbatch = 1; m_rem = int'(cmd_count); end
      else dn = 1;
    end else if (m_inbatch && m_rem == 0 && m_out == 0) begin
      m_inbatch = 0; dn = 1;
    end
    if (pop) void'(m_q.pop_front());
    if (r_acc) begin
      if (m_out > 0) begin
        m_q.push_back(ret_data); m_sum = m_sum + {16'd0, ret_data}; m_out--;
      end else m_err = 1;
      if (comp_en && comp_q.size() > 0) void'(comp_q.pop_front());
    end
    if (c_acc) begin
      m_rem--; m_out++;
      d = (dir_q.size() > 0) ? dir_q.pop_front() : $urandom;
      comp_q.push_back(d);
      gen_sum = gen_sum + {16'd0, d};
    end
    m_done = dn;
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input int n);
    cmd_count = 16'(n);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_batch();
    for (int i = 0; i < 400 && m_inbatch; i++) tick();
    check("batch timeout", m_inbatch, 0);
    tick();
  endtask

  task automatic check_reset_values();
    check("rst cmd_ready", cmd_ready, 1);
    check("rst call_start", call_start, 0);
    check("rst ret_stall", ret_stall, 0);
    check("rst res_valid", res_valid, 0);
    check("rst res_data", res_data, 0);
    check("rst batch_sum", batch_sum, 0);
    check("rst batch_done", batch_done, 0);
    check("rst err_unexp", err_unexp, 0);
  endtask

  initial begin
    int c0, d0;
    model_reset();
    #2;
    check_reset_values();
    @(posedge clock); #1;
    resetn = 1'b1;

    // Three calls with returns 10,20,30 one cycle after each call.
    res_ready = 1'b1; gen_sum = '0;
    dir_q.push_back(32'd10); dir_q.push_back(32'd20); dir_q.push_back(32'd30);
    c0 = obs_calls; d0 = obs_done; obs_pops.delete();
    issue(3);
    finish_batch();
    tick(); tick();
    check("041 calls", obs_calls - c0, 3);
    check("041 sum", batch_sum, 60);
    check("041 done pulses", obs_done - d0, 1);
    check("041 pop count", obs_pops.size(), 3);
    if (obs_pops.size() == 3) begin
      check("041 pop0", obs_pops[0], 10);
      check("041 pop1", obs_pops[1], 20);
      check("041 pop2", obs_pops[2], 30);
    end

    // Credit limit with a blocked consumer.
    res_ready = 1'b0; gen_sum = '0; c0 = obs_calls;
    issue(8);
    for (int i = 0; i < 12; i++) tick();
    check("042 calls before drain", obs_calls - c0, DEPTH);
    check("042 stall", ret_stall, 1);
    check("042 call_start", call_start, 0);
    res_ready = 1'b1;
    finish_batch();
    check("042 calls total", obs_calls - c0, 8);
    check("042 sum", batch_sum, gen_sum);
    for (int i = 0; i < 6; i++) tick();

    // Busy component holds call_start.
    c0 = obs_calls;
    issue(2);
    call_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("043 start held", call_start, 1);
    end
    check("043 no accept while busy", obs_calls - c0, 0);
    call_busy = 1'b0;
    tick();
    check("043 single accept", obs_calls - c0, 1);
    finish_batch();

    // Empty batch.
    d0 = obs_done; c0 = obs_calls;
    issue(0);
    check("044 done", batch_done, 1);
    check("044 sum", batch_sum, 0);
    tick();
    check("044 no calls", obs_calls - c0, 0);
    check("044 one pulse", obs_done - d0, 1);

    // Unexpected return in idle.
    comp_en = 1'b0;
    ret_done = 1'b1; ret_data = 32'h55;
    tick();
    ret_done = 1'b0;
    tick();
    check("045 err", err_unexp, 1);
    check("045 res_valid", res_valid, 0);
    check("045 sum", batch_sum, 0);

    // Reset with two calls in flight and two results buffered.
    res_ready = 1'b0;
    issue(4);
    for (int i = 0; i < 5; i++) tick();
    ret_done = 1'b1;
    ret_data = 32'hA1; tick();
    ret_data = 32'hB2; tick();
    ret_done = 1'b0;
    check("046 buffered", res_valid, 1);
    resetn = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(posedge clock); #1;
    resetn = 1'b1;
    comp_en = 1'b1; res_ready = 1'b1; gen_sum = '0; c0 = obs_calls;
    issue(1);
    finish_batch();
    check("046 recovered calls", obs_calls - c0, 1);
    check("046 recovered sum", batch_sum, gen_sum);

    // Randomized batches with random stalls, returns and consumer pressure.
    rand_mode = 1'b1; ret_pct = 60;
    for (int b = 0; b < 25; b++) begin
      gen_sum = '0;
      issue($urandom_range(0, 10));
      finish_batch();
      check("rand batch sum", batch_sum, gen_sum);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/example_call_driver.md
EXAMPLE_CALL_DRIVER -- requirements
Module: example_call_driver

Interface
REQ-001 Parameter: DEPTH, 4, result FIFO depth and maximum credits (power of two, 2..16).
REQ-002 Port: clock  in  1  single clock, all logic rising-edge.
REQ-003 Port: resetn  in  1  reset, asynchronous assert, active-low.
REQ-004 Port: cmd_valid  in  1  batch request valid.
REQ-005 Port: cmd_ready  out  1  batch request accepted when cmd_valid and cmd_ready are both 1.
REQ-006 Port: cmd_count  in  16  number of component calls in the batch.
REQ-007 Port: call_start  out  1  call valid to the component (drives component start).
REQ-008 Port: call_busy  in  1  component call stall; a call is accepted in a cycle with call_start=1 and call_busy=0.
REQ-009 Port: ret_done  in  1  component return valid.
REQ-010 Port: ret_stall  out  1  return backpressure; a return is accepted in a cycle with ret_done=1 and ret_stall=0.
REQ-011 Port: ret_data  in  32  component returndata.
REQ-012 Port: res_valid  out  1  buffered result valid.
REQ-013 Port: res_ready  in  1  downstream pop; pop occurs when res_valid=1 and res_ready=1.
REQ-014 Port: res_data  out  32  FIFO head data.
REQ-015 Port: batch_sum  out  48  zero-extended sum of accepted ret_data in the current batch.
REQ-016 Port: batch_done  out  1  one-cycle pulse at batch completion.
REQ-017 Port: err_unexp  out  1  sticky flag, ret_done=1 seen with zero outstanding calls.

Function
REQ-018 States: IDLE, ISSUE, DRAIN; cmd_ready=1 only in IDLE.
REQ-019 IDLE: a command with cmd_count>0 loads remaining=cmd_count, clears batch_sum and goes to ISSUE next cycle.
REQ-020 IDLE: a command with cmd_count=0 stays in IDLE, clears batch_sum and pulses batch_done in the next cycle.
REQ-021 Credit: outstanding (calls accepted, return not yet accepted) + FIFO occupancy is at most DEPTH at all times.
REQ-022 call_start=1 in ISSUE only, while remaining>0 and outstanding+occupancy<DEPTH; combinational from registered state.
REQ-023 Once asserted, call_start stays 1 until the call is accepted, whatever call_busy does.
REQ-024 Call acceptance: remaining decrements and outstanding increments; when the last call is accepted, go to DRAIN next cycle.
REQ-025 DRAIN: call_start=0; when outstanding=0, return to IDLE and pulse batch_done for one cycle.
REQ-026 The batch_done pulse does not wait for the FIFO to empty.
REQ-027 ret_stall=1 iff FIFO is full (registered occupancy=DEPTH); ret_stall=0 otherwise.
REQ-028 Return acceptance with outstanding>0: push ret_data, decrement outstanding, add ret_data to batch_sum.
REQ-029 batch_sum wraps modulo 2^48.
REQ-030 Return acceptance with outstanding=0: no push, no sum update, set err_unexp; cleared only by reset.
REQ-031 Returns are accepted in any state, including IDLE.
REQ-032 Same-cycle call acceptance and return acceptance: outstanding unchanged.
REQ-033 Same-cycle push and pop: occupancy unchanged, order preserved.
REQ-034 Pop on an empty FIFO is impossible, because res_valid=0.
REQ-035 res_valid=1 iff occupancy>0; res_data is the registered FIFO head, valid the cycle after the push.
REQ-036 Push-to-res_valid latency is 1 cycle; call-to-call throughput is 1 per cycle while credits allow.
REQ-037 FIFO pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.

Reset
REQ-038 On resetn=0: state=IDLE, remaining=0, outstanding=0, FIFO empty, batch_sum=0, err_unexp=0, batch_done=0, call_start=0, ret_stall=0, res_valid=0, res_data=0.
REQ-039 Reset mid-batch discards all calls in flight and buffered results.
REQ-040 After reset the block is usable the first cycle after resetn rises.

Verification
REQ-041 cmd_count=3, call_busy=0, component returns 10,20,30 one cycle after each call, res_ready=1 -> 3 call starts, res_data 10,20,30 in order, batch_sum=60, one batch_done pulse.
REQ-042 cmd_count=8, DEPTH=4, res_ready=0, immediate returns -> exactly 4 calls accepted, FIFO full, ret_stall=1, call_start=0; after res_ready=1 the remaining 4 complete, batch_sum correct.
REQ-043 call_busy=1 for 5 cycles during ISSUE -> call_start held 1 throughout, remaining unchanged, single acceptance when call_busy falls.
REQ-044 cmd_count=0 -> cmd_ready=1 retained, no call_start, batch_done pulse next cycle, batch_sum=0.
REQ-045 ret_done=1 in IDLE with no calls -> err_unexp=1, res_valid=0, batch_sum unchanged.
REQ-046 resetn=0 with 2 outstanding and 2 buffered -> all outputs at reset values; a new cmd_count=1 then completes normally.
